// File: rtl/muldiv_ctl.sv
// rtl/muldiv_ctl.sv - HI/LO owner and 1-bit/cycle MULT/DIV sequencer beside the EX-stage ALU
module muldiv_ctl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              md_valid_i,
    input  logic [2:0]        md_op_i,
    input  logic [DATA_W-1:0] md_rs_i,
    input  logic [DATA_W-1:0] md_rt_i,
    output logic              md_stall_o,
    output logic              md_busy_o,
    output logic [DATA_W-1:0] md_rdata_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MFHI  = 3'b110;
    localparam logic [2:0] OP_MFLO  = 3'b111;

    state_t              state;
    logic [CNT_W-1:0]    count;
    logic [2*DATA_W-1:0] acc;
    logic [DATA_W-1:0]   opb;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic                is_div;
    logic                neg_lo;
    logic                neg_hi;

    logic              idle;
    logic              accept;
    logic              signed_op;
    logic              rs_neg;
    logic              rt_neg;
    logic [DATA_W-1:0] rs_abs;
    logic [DATA_W-1:0] rt_abs;
    logic              last_iter;

    assign idle      = (state == S_IDLE);
    assign accept    = idle & md_valid_i;
    assign signed_op = (md_op_i == OP_MULT) | (md_op_i == OP_DIV);
    assign rs_neg    = signed_op & md_rs_i[DATA_W-1];
    assign rt_neg    = signed_op & md_rt_i[DATA_W-1];
    assign rs_abs    = rs_neg ? -md_rs_i : md_rs_i;
    assign rt_abs    = rt_neg ? -md_rt_i : md_rt_i;
    assign last_iter = (count == CNT_W'(DATA_W - 1));

    // acc holds {partial product, remaining multiplier} while multiplying
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opb} : '0);
    assign mul_next = {mul_sum, acc[DATA_W-1:1]};

    // and {remainder, dividend/quotient} while dividing
    logic [DATA_W:0]     div_sh;
    logic [DATA_W:0]     div_diff;
    logic                div_ge;
    logic [2*DATA_W-1:0] div_next;
    assign div_sh   = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    assign div_ge   = (div_sh >= {1'b0, opb});
    assign div_diff = div_sh - {1'b0, opb};
    assign div_next = {(div_ge ? div_diff[DATA_W-1:0] : div_sh[DATA_W-1:0]),
                       acc[DATA_W-2:0], div_ge};

    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;
    assign prod_fix = neg_lo ? -acc : acc;
    assign quo_fix  = neg_lo ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    assign rem_fix  = neg_hi ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            count  <= '0;
            acc    <= '0;
            opb    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    count <= '0;
                    case (md_op_i)
                        OP_MULT, OP_MULTU: begin
                            state  <= S_MUL;
                            is_div <= 1'b0;
                            acc    <= {{DATA_W{1'b0}}, rt_abs};
                            opb    <= rs_abs;
                            neg_lo <= rs_neg ^ rt_neg;
                            neg_hi <= 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            is_div <= 1'b1;
                            if (md_rt_i == '0) begin
                                // divide-by-zero: raw rs to HI, all ones to LO via FIX
                                state  <= S_FIX;
                                acc    <= {md_rs_i, {DATA_W{1'b1}}};
                                neg_lo <= 1'b0;
                                neg_hi <= 1'b0;
                            end else begin
                                state  <= S_DIV;
                                acc    <= {{DATA_W{1'b0}}, rs_abs};
                                opb    <= rt_abs;
                                neg_lo <= rs_neg ^ rt_neg;
                                neg_hi <= rs_neg;
                            end
                        end
                        OP_MTHI: hi_q <= md_rs_i;
                        OP_MTLO: lo_q <= md_rs_i;
                        default: ;
                    endcase
                end
                S_MUL: begin
                    acc   <= mul_next;
                    count <= count + 1'b1;
                    if (last_iter) state <= S_FIX;
                end
                S_DIV: begin
                    acc   <= div_next;
                    count <= count + 1'b1;
                    if (last_iter) state <= S_FIX;
                end
                S_FIX: begin
                    state <= S_IDLE;
                    if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*DATA_W-1:DATA_W];
                        lo_q <= prod_fix[DATA_W-1:0];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign md_busy_o  = ~idle;
    assign md_stall_o = md_valid_i & ~idle;
    assign md_rdata_o = (accept && md_op_i == OP_MFHI) ? hi_q :
                        (accept && md_op_i == OP_MFLO) ? lo_q : '0;
    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_ctl.sv
// tb/tb_muldiv_ctl.sv - scoreboard bench for muldiv_ctl
module tb_muldiv_ctl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        md_valid_i;
    logic [2:0]  md_op_i;
    logic [31:0] md_rs_i;
    logic [31:0] md_rt_i;
    logic        md_stall_o;
    logic        md_busy_o;
    logic [31:0] md_rdata_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_checks = 0;
    int n_fails  = 0;
    logic [63:0] exp_q[$];

    muldiv_ctl #(.DATA_W(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .md_valid_i (md_valid_i),
        .md_op_i    (md_op_i),
        .md_rs_i    (md_rs_i),
        .md_rt_i    (md_rt_i),
        .md_stall_o (md_stall_o),
        .md_busy_o  (md_busy_o),
        .md_rdata_o (md_rdata_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'b000: p = 64'(sa * sb);
            3'b001: p = {32'b0, a} * {32'b0, b};
            3'b010: begin
                if (b == 0) return {a, 32'hffffffff};
                q = sa / sb;
                r = sa % sb;
                p = {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hffffffff};
                p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    task automatic wait_idle(output int n);
        n = 0;
        while (md_busy_o && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cycles);
        int n;
        logic [63:0] e;
        exp_q.push_back(model(op, a, b));
        md_valid_i = 1'b1; md_op_i = op; md_rs_i = a; md_rt_i = b;
        #1;
        check_eq({tag, "_accept_stall"}, 64'(md_stall_o), 64'd0);
        @(posedge clk); #1;
        md_valid_i = 1'b0;
        check_eq({tag, "_busy_after_accept"}, 64'(md_busy_o), 64'd1);
        wait_idle(n);
        check_eq({tag, "_busy_cycles"}, 64'(n), 64'(exp_cycles));
        e = exp_q.pop_front();
        check_eq({tag, "_hilo"}, {hi_o, lo_o}, e);
    endtask

    initial begin
        int n;
        logic [63:0] e;
        rst_n = 1'b0; md_valid_i = 1'b0; md_op_i = '0; md_rs_i = '0; md_rt_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy",  64'(md_busy_o),  64'd0);
        check_eq("rst_stall", 64'(md_stall_o), 64'd0);
        check_eq("rst_rdata", 64'(md_rdata_o), 64'd0);
        check_eq("rst_hilo",  {hi_o, lo_o},    64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("multu_max", 3'b001, 32'hffffffff, 32'hffffffff, 33);
        check_eq("multu_max_const", {hi_o, lo_o}, 64'hfffffffe_00000001);
        run_op("mult_neg",  3'b000, 32'hfffffffd, 32'd5, 33);
        check_eq("mult_neg_const", {hi_o, lo_o}, 64'hffffffff_fffffff1);
        run_op("div_neg",   3'b010, 32'hfffffff9, 32'd2, 33);
        check_eq("div_neg_const", {hi_o, lo_o}, 64'hffffffff_fffffffd);
        run_op("divu_7_2",  3'b011, 32'd7, 32'd2, 33);
        check_eq("divu_const", {hi_o, lo_o}, 64'h00000001_00000003);
        run_op("div_ovf",   3'b010, 32'h80000000, 32'hffffffff, 33);
        check_eq("div_ovf_const", {hi_o, lo_o}, 64'h00000000_80000000);
        run_op("div_mixed", 3'b010, 32'd100, 32'hfffffff9, 33);
        run_op("mult_rand", 3'b000, 32'h8765_4321, 32'h1357_9bdf, 33);
        run_op("divu_zero", 3'b011, 32'h1234, 32'd0, 1);
        check_eq("divu_zero_const", {hi_o, lo_o}, 64'h00001234_ffffffff);
        run_op("div_zero_s", 3'b010, 32'hfffffff0, 32'd0, 1);

        // MULT then MFLO held in EX: stalls until the product lands
        exp_q.push_back(model(3'b000, 32'd1234567, 32'hffff0001));
        md_valid_i = 1'b1; md_op_i = 3'b000; md_rs_i = 32'd1234567; md_rt_i = 32'hffff0001;
        @(posedge clk); #1;
        md_op_i = 3'b111;
        #1;
        check_eq("mflo_stall_first", 64'(md_stall_o), 64'd1);
        check_eq("mflo_rdata_busy",  64'(md_rdata_o), 64'd0);
        n = 0;
        while (md_busy_o && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (md_busy_o) begin
                if (md_stall_o !== 1'b1) check_eq("mflo_stall_hold", 64'(md_stall_o), 64'd1);
            end
        end
        check_eq("mflo_wait_cycles", 64'(n), 64'd33);
        e = exp_q.pop_front();
        check_eq("mflo_stall_release", 64'(md_stall_o), 64'd0);
        check_eq("mflo_rdata_new", 64'(md_rdata_o), 64'(e[31:0]));
        check_eq("mflo_hilo", {hi_o, lo_o}, e);
        md_valid_i = 1'b0;
        #1;
        check_eq("rdata_idle_novalid", 64'(md_rdata_o), 64'd0);

        // busy DIV rejects a new MULT without disturbing HI/LO
        md_valid_i = 1'b1; md_op_i = 3'b011; md_rs_i = 32'd50; md_rt_i = 32'd7;
        @(posedge clk); #1;
        md_op_i = 3'b001; md_rs_i = 32'd3; md_rt_i = 32'd3;
        #1;
        check_eq("busy_newop_stall", 64'(md_stall_o), 64'd1);
        md_valid_i = 1'b0;
        wait_idle(n);
        check_eq("busy_newop_result", {hi_o, lo_o}, 64'h00000001_00000007);

        // reset mid-multiply
        md_valid_i = 1'b1; md_op_i = 3'b001; md_rs_i = 32'd9; md_rt_i = 32'd9;
        @(posedge clk); #1;
        md_valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", 64'(md_busy_o), 64'd0);
        check_eq("midrst_hilo", {hi_o, lo_o}, 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        md_valid_i = 1'b1; md_op_i = 3'b100; md_rs_i = 32'h0000abcd;
        #1;
        check_eq("mthi_stall", 64'(md_stall_o), 64'd0);
        @(posedge clk); #1;
        md_op_i = 3'b110; md_rs_i = 32'h5555;
        #1;
        check_eq("mfhi_stall", 64'(md_stall_o), 64'd0);
        check_eq("mfhi_rdata", 64'(md_rdata_o), 64'h0000abcd);
        check_eq("mfhi_hi",    64'(hi_o),       64'h0000abcd);
        md_op_i = 3'b101; md_rs_i = 32'hcafe0001;
        @(posedge clk); #1;
        md_op_i = 3'b111;
        #1;
        check_eq("mflo_after_mtlo", 64'(md_rdata_o), 64'hcafe0001);
        md_valid_i = 1'b0;

        check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
